// File: rtl/j_mac_accum.sv
// Jerry DSP multiply-accumulate: signed 16x16 multiply into a 40-bit wrapping accumulator, two-stage pipe.
// Optional sticky overflow flag on port `ovf` when J_MAC_OVF_FLAG_EN is defined.
module j_mac_accum (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic               go,
  input  logic [1:0]         op,
  input  logic signed [15:0] a,
  input  logic signed [15:0] b,
  input  logic               stall,
  output logic [31:0]        acc_lo,
  output logic               accum_32,
  output logic               accum_33,
  output logic               accum_34,
  output logic               accum_35,
  output logic               accum_36,
  output logic               accum_37,
  output logic               accum_38,
  output logic               accum_39,
  output logic               done
`ifdef J_MAC_OVF_FLAG_EN
  ,
  output logic               ovf
`endif
);

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = 40;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_ADD   = 2'd1,
    OP_SUB   = 2'd2,
    OP_CLEAR = 2'd3
  } op_e;

  function automatic logic signed [ACC_W-1:0] acc_apply(
    input op_e                      opc,
    input logic signed [ACC_W-1:0]  acc,
    input logic signed [PROD_W-1:0] prod
  );
    logic signed [ACC_W-1:0] prod_ext;
    prod_ext  = prod;
    acc_apply = '0;
    unique case (opc)
      OP_LOAD:  acc_apply = prod_ext;
      OP_ADD:   acc_apply = acc + prod_ext;
      OP_SUB:   acc_apply = acc - prod_ext;
      OP_CLEAR: acc_apply = '0;
    endcase
  endfunction

`ifdef J_MAC_OVF_FLAG_EN
  // Signed overflow: both addends share a sign and the wrapped sum does not.
  function automatic logic add_ovf(
    input op_e                      opc,
    input logic signed [ACC_W-1:0]  acc,
    input logic signed [PROD_W-1:0] prod
  );
    logic signed [ACC_W-1:0] addend;
    logic signed [ACC_W-1:0] sum;
    addend  = prod;
    if (opc == OP_SUB) addend = -addend;
    sum     = acc + addend;
    add_ovf = (acc[ACC_W-1] == addend[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
  endfunction
`endif

  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] b_ext;
  logic signed [PROD_W-1:0] prod_c;

  logic signed [PROD_W-1:0] prod_p1;
  op_e                      op_p1;
  logic                     vld_p1;

  logic signed [ACC_W-1:0]  acc_p2;
  logic                     vld_p2;
  logic signed [ACC_W-1:0]  acc_next;

  assign a_ext  = a;
  assign b_ext  = b;
  assign prod_c = a_ext * b_ext;

  // ---- Stage 1: multiply ----
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      prod_p1 <= '0;
      op_p1   <= OP_LOAD;
      vld_p1  <= 1'b0;
    end else if (!stall) begin
      vld_p1 <= go;
      if (go) begin
        prod_p1 <= prod_c;
        op_p1   <= op_e'(op);
      end
    end
  end

  assign acc_next = acc_apply(op_p1, acc_p2, prod_p1);

  // ---- Stage 2: accumulate ----
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      acc_p2 <= '0;
      vld_p2 <= 1'b0;
    end else if (!stall) begin
      vld_p2 <= vld_p1;
      if (vld_p1) acc_p2 <= acc_next;
    end
  end

`ifdef J_MAC_OVF_FLAG_EN
  logic ovf_p2;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      ovf_p2 <= 1'b0;
    end else if (!stall && vld_p1) begin
      unique case (op_p1)
        OP_LOAD, OP_CLEAR: ovf_p2 <= 1'b0;
        OP_ADD, OP_SUB: begin
          if (add_ovf(op_p1, acc_p2, prod_p1)) ovf_p2 <= 1'b1;
        end
      endcase
    end
  end

  assign ovf = ovf_p2;
`endif

  assign acc_lo   = acc_p2[31:0];
  assign accum_32 = acc_p2[32];
  assign accum_33 = acc_p2[33];
  assign accum_34 = acc_p2[34];
  assign accum_35 = acc_p2[35];
  assign accum_36 = acc_p2[36];
  assign accum_37 = acc_p2[37];
  assign accum_38 = acc_p2[38];
  assign accum_39 = acc_p2[39];
  assign done     = vld_p2;

endmodule

// File: tb/tb_j_mac_accum.sv
// Testbench for j_mac_accum: directed test-plan steps plus randomized traffic against a queue-based reference model.
module tb_j_mac_accum;

  logic               sys_clk = 1'b0;
  logic               reset = 1'b1;
  logic               go = 1'b0;
  logic [1:0]         op = 2'd0;
  logic signed [15:0] a = '0;
  logic signed [15:0] b = '0;
  logic               stall = 1'b0;
  logic [31:0]        acc_lo;
  logic               accum_32, accum_33, accum_34, accum_35;
  logic               accum_36, accum_37, accum_38, accum_39;
  logic               done;
`ifdef J_MAC_OVF_FLAG_EN
  logic               ovf;
`endif

  j_mac_accum dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .go      (go),
    .op      (op),
    .a       (a),
    .b       (b),
    .stall   (stall),
    .acc_lo  (acc_lo),
    .accum_32(accum_32),
    .accum_33(accum_33),
    .accum_34(accum_34),
    .accum_35(accum_35),
    .accum_36(accum_36),
    .accum_37(accum_37),
    .accum_38(accum_38),
    .accum_39(accum_39),
    .done    (done)
`ifdef J_MAC_OVF_FLAG_EN
    ,
    .ovf     (ovf)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [1:0]         op;
    logic signed [15:0] a;
    logic signed [15:0] b;
  } op_t;

  op_t         pend[$];
  logic [39:0] exp_acc = '0;
  logic        exp_done = 1'b0;
  logic        exp_ovf = 1'b0;
  int          checks = 0;
  int          failures = 0;

  localparam longint ACC_MAX = (64'sd1 <<< 39) - 1;
  localparam longint ACC_MIN = -(64'sd1 <<< 39);

  function automatic logic [39:0] dut_acc();
    return {accum_39, accum_38, accum_37, accum_36, accum_35, accum_34, accum_33, accum_32, acc_lo};
  endfunction

  // Commit one operation using exact 64-bit arithmetic, then wrap to 40 bits.
  task automatic apply(input op_t t);
    longint p, s, r;
    p = longint'(t.a) * longint'(t.b);
    s = longint'($signed(exp_acc));
    r = 0;
    case (t.op)
      2'd0: begin exp_acc = p[39:0]; exp_ovf = 1'b0; end
      2'd1, 2'd2: begin
        r = (t.op == 2'd1) ? s + p : s - p;
        if (r > ACC_MAX || r < ACC_MIN) exp_ovf = 1'b1;
        exp_acc = r[39:0];
      end
      default: begin exp_acc = '0; exp_ovf = 1'b0; end
    endcase
  endtask

  // An op accepted on one unstalled edge commits on the next unstalled edge.
  task automatic model_edge();
    op_t t;
    if (reset) begin
      pend.delete();
      exp_acc  = '0;
      exp_done = 1'b0;
      exp_ovf  = 1'b0;
    end else if (!stall) begin
      exp_done = 1'b0;
      if (pend.size() > 0) begin
        t = pend.pop_front();
        apply(t);
        exp_done = 1'b1;
      end
      if (go) begin
        t.op = op; t.a = a; t.b = b;
        pend.push_back(t);
      end
    end
  endtask

  task automatic check_model(input string tag);
    checks++;
    assert (dut_acc() === exp_acc) else begin
      failures++;
      $error("FAIL %s acc got=%h exp=%h", tag, dut_acc(), exp_acc);
    end
    checks++;
    assert (done === exp_done) else begin
      failures++;
      $error("FAIL %s done got=%b exp=%b", tag, done, exp_done);
    end
`ifdef J_MAC_OVF_FLAG_EN
    checks++;
    assert (ovf === exp_ovf) else begin
      failures++;
      $error("FAIL %s ovf got=%b exp=%b", tag, ovf, exp_ovf);
    end
`endif
  endtask

  task automatic expect_const(input string tag, input logic [39:0] v, input logic d);
    checks++;
    assert (dut_acc() === v) else begin
      failures++;
      $error("FAIL %s acc got=%h exp=%h", tag, dut_acc(), v);
    end
    checks++;
    assert (done === d) else begin
      failures++;
      $error("FAIL %s done got=%b exp=%b", tag, done, d);
    end
  endtask

  task automatic step(input logic g, input logic [1:0] o, input logic [15:0] aa,
                      input logic [15:0] bb, input logic st, input logic rs, input string tag);
    go = g; op = o; a = aa; b = bb; stall = st; reset = rs;
    @(posedge sys_clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0, tag);
  endtask

  function automatic logic [15:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'hFFFF;
      default: return 16'($urandom());
    endcase
  endfunction

  initial begin
    // Reset state
    step(1'b0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b1, "reset");
    step(1'b0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b1, "reset2");
    expect_const("reset_state", 40'h0, 1'b0);

    // 1: max positive product
    step(1'b1, 2'd0, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, "t1_issue");
    expect_const("t1_not_yet", 40'h0, 1'b0);
    idle("t1_commit");
    expect_const("t1_value", 40'h00_3FFF0001, 1'b1);

    // 2: -32768^2 then streamed SUB
    step(1'b1, 2'd0, 16'h8000, 16'h8000, 1'b0, 1'b0, "t2_load");
    step(1'b1, 2'd2, 16'h0001, 16'h0001, 1'b0, 1'b0, "t2_sub");
    expect_const("t2_first", 40'h00_40000000, 1'b1);
    idle("t2_commit_sub");
    expect_const("t2_second", 40'h00_3FFFFFFF, 1'b1);
    idle("t2_drain");
    expect_const("t2_done_drop", 40'h00_3FFFFFFF, 1'b0);

    // 3: negative product sign-extends
    step(1'b1, 2'd0, 16'hFFFF, 16'h0003, 1'b0, 1'b0, "t3_issue");
    idle("t3_commit");
    expect_const("t3_value", 40'hFF_FFFFFFFD, 1'b1);

    // 4: accumulate to the wrap point
    step(1'b1, 2'd0, 16'h8000, 16'h8000, 1'b0, 1'b0, "t4_load");
    for (int i = 0; i < 511; i++) step(1'b1, 2'd1, 16'h8000, 16'h8000, 1'b0, 1'b0, "t4_add");
    idle("t4_last");
    expect_const("t4_wrap", 40'h80_00000000, 1'b1);
`ifdef J_MAC_OVF_FLAG_EN
    checks++;
    assert (ovf === 1'b1) else begin
      failures++;
      $error("FAIL t4_ovf got=%b exp=1", ovf);
    end
`endif
    step(1'b1, 2'd3, 16'h1234, 16'h5678, 1'b0, 1'b0, "t4_clear");
    idle("t4_clear_commit");
    expect_const("t4_cleared", 40'h0, 1'b1);

    // 5: stall holds everything, go during stall is dropped
    step(1'b1, 2'd0, 16'h0010, 16'h0010, 1'b0, 1'b0, "t5_load");
    step(1'b1, 2'd1, 16'h0002, 16'h0003, 1'b0, 1'b0, "t5_add");
    for (int i = 0; i < 3; i++) step(1'b1, 2'd1, 16'h0100, 16'h0100, 1'b1, 1'b0, "t5_stall");
    expect_const("t5_frozen", 40'h0000000100, 1'b1);
    idle("t5_release");
    expect_const("t5_commit", 40'h0000000106, 1'b1);
    idle("t5_no_dropped_commit");
    expect_const("t5_after", 40'h0000000106, 1'b0);

    // 6: reset discards in-flight ops
    step(1'b1, 2'd1, 16'h0005, 16'h0005, 1'b0, 1'b0, "t6_op1");
    step(1'b1, 2'd1, 16'h0007, 16'h0007, 1'b0, 1'b0, "t6_op2");
    step(1'b1, 2'd1, 16'h0009, 16'h0009, 1'b1, 1'b1, "t6_reset");
    expect_const("t6_reset_state", 40'h0, 1'b0);
    idle("t6_idle1");
    expect_const("t6_no_stale", 40'h0, 1'b0);
    idle("t6_idle2");

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), rand_operand(), rand_operand(),
           1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 60) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
